// File: rtl/norm_shift_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// norm_shift_ctrl_pkg : FSM states and shift-direction constants (rev 1.0)
// ------------------------------------------------------------------------
package norm_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ENCODE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic SHIFT_LEFT  = 1'b1;
  localparam logic SHIFT_RIGHT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/norm_shift_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// norm_shift_ctrl_if : upstream/downstream handshake bundle (rev 1.0)
// ------------------------------------------------------------------------
interface norm_shift_ctrl_if #(
  parameter int SWR = 26,
  parameter int EWR = 5,
  parameter int EW  = 8
);
  logic           valid_i;
  logic           ready_o;
  logic [SWR-1:0] Add_Subt_result_i;
  logic [EW-1:0]  Exp_i;
  logic           valid_o;
  logic           ready_i;
  logic [EWR-1:0] Shift_Value_o;
  logic           Left_Right_o;
  logic           Bit_Shift_o;
  logic           load_o;
  logic [EW-1:0]  Exp_o;
  logic           zero_o;
  logic           underflow_o;

  modport master (
    output valid_i, Add_Subt_result_i, Exp_i, ready_i,
    input  ready_o, valid_o, Shift_Value_o, Left_Right_o, Bit_Shift_o,
           load_o, Exp_o, zero_o, underflow_o
  );

  modport slave (
    input  valid_i, Add_Subt_result_i, Exp_i, ready_i,
    output ready_o, valid_o, Shift_Value_o, Left_Right_o, Bit_Shift_o,
           load_o, Exp_o, zero_o, underflow_o
  );
endinterface
`default_nettype wire

// File: rtl/lzc_encoder.sv
`default_nettype none
// ------------------------------------------------------------------------
// lzc_encoder : leading-zero counter with all-zero flag (rev 1.0)
// ------------------------------------------------------------------------
module lzc_encoder #(
  parameter int WIDTH = 25,
  parameter int CNT_W = 5
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  // Scan upward so the most significant set bit is the last to win.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|data;

endmodule
`default_nettype wire

// File: rtl/norm_shift_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// norm_shift_ctrl : normalization shift controller; optional macro
// NORM_SHIFT_CLAMP_EN clamps left shifts to the exponent (rev 1.0)
// ------------------------------------------------------------------------
module norm_shift_ctrl
  import norm_shift_ctrl_pkg::*;
#(
  parameter int SWR = 26,
  parameter int EWR = 5,
  parameter int EW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  norm_shift_ctrl_if.slave   bus
);

  localparam int XW = (EW > EWR) ? EW : EWR;

  state_t         state, state_nxt;
  logic           ready;
  logic           accept;

  logic [SWR-1:0] data_q;
  logic [EW-1:0]  exp_q;
  logic           ovf_q;
  logic           zero_q;
  logic [EWR-1:0] lz_q;

  logic [EWR-1:0] lz_cnt;
  logic           lz_zero;

  logic [EWR-1:0] shift_n;
  logic           dir_n;
  logic [EW-1:0]  exp_n;
  logic           zero_n;
  logic           uf_n;

  logic           valid_q;
  logic [EWR-1:0] shift_q;
  logic           dir_q;
  logic           fill_q;
  logic [EW-1:0]  exp_out_q;
  logic           zero_out_q;
  logic           uf_q;

  assign ready  = !rst && ((state == IDLE) || ((state == PRESENT) && bus.ready_i));
  assign accept = bus.valid_i && ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.valid_i) state_nxt = CAPTURE;
      CAPTURE: state_nxt = ENCODE;
      ENCODE:  state_nxt = PRESENT;
      PRESENT: if (bus.ready_i) state_nxt = bus.valid_i ? CAPTURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      exp_q  <= '0;
    end else if (accept) begin
      data_q <= bus.Add_Subt_result_i;
      exp_q  <= bus.Exp_i;
    end
  end

  lzc_encoder #(
    .WIDTH (SWR - 1),
    .CNT_W (EWR)
  ) u_lzc (
    .data     (data_q[SWR-2:0]),
    .count    (lz_cnt),
    .all_zero (lz_zero)
  );

  // CAPTURE registers the classification so ENCODE only does exponent math.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      lz_q   <= '0;
    end else if (state == CAPTURE) begin
      ovf_q  <= data_q[SWR-1];
      zero_q <= !data_q[SWR-1] && lz_zero;
      lz_q   <= lz_cnt;
    end
  end

  always_comb begin
    shift_n = '0;
    dir_n   = SHIFT_LEFT;
    exp_n   = exp_q - EW'(lz_q);
    zero_n  = 1'b0;
    uf_n    = 1'b0;
    if (ovf_q) begin
      shift_n = EWR'(1);
      dir_n   = SHIFT_RIGHT;
      exp_n   = exp_q + EW'(1);
    end else if (zero_q) begin
      zero_n  = 1'b1;
      exp_n   = '0;
    end else begin
      shift_n = lz_q;
      uf_n    = XW'(lz_q) > XW'(exp_q);
`ifdef NORM_SHIFT_CLAMP_EN
      // Denormal: shift only as far as the exponent allows.
      if (uf_n) begin
        shift_n = EWR'(exp_q);
        exp_n   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      shift_q    <= '0;
      dir_q      <= 1'b0;
      fill_q     <= 1'b0;
      exp_out_q  <= '0;
      zero_out_q <= 1'b0;
      uf_q       <= 1'b0;
    end else if (state == ENCODE) begin
      valid_q    <= 1'b1;
      shift_q    <= shift_n;
      dir_q      <= dir_n;
      fill_q     <= 1'b0;
      exp_out_q  <= exp_n;
      zero_out_q <= zero_n;
      uf_q       <= uf_n;
    end else if ((state == PRESENT) && bus.ready_i) begin
      valid_q    <= 1'b0;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.valid_o       = valid_q;
  assign bus.load_o        = !rst && valid_q && bus.ready_i;
  assign bus.Shift_Value_o = shift_q;
  assign bus.Left_Right_o  = dir_q;
  assign bus.Bit_Shift_o   = fill_q;
  assign bus.Exp_o         = exp_out_q;
  assign bus.zero_o        = zero_out_q;
  assign bus.underflow_o   = uf_q;

endmodule
`default_nettype wire
